operand_fetch: RTL and testbench

- Decode/operand-fetch stage that sits directly upstream of the 8-bit, 7-entry register file (r1–r7; r0 reads zero) and owns its port.
- Accepts 16-bit instructions over a valid/ready handshake and issues the register-file reads.
- Passes writeback traffic through to the register file's write port with priority.
- Presents an operand bundle (op, rd, A, B) to execute over a valid/ready handshake, with writeback forwarding.

---
 rtl/operand_fetch.sv | 163 ++++++++++++++++
 tb/tb_operand_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: latches an instruction, reads the register file,
// captures operands with writeback forwarding and hands a bundle to execute.
module operand_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        wb_valid,
    input  logic [2:0]  wb_rd,
    input  logic [7:0]  wb_data,
    output logic [2:0]  rf_rs,
    output logic [2:0]  rf_rt,
    output logic [2:0]  rf_rd,
    output logic        rf_rw,
    output logic [7:0]  rf_rd_data,
    input  logic [7:0]  rf_rs_data,
    input  logic [7:0]  rf_rt_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [2:0]  out_rd,
    output logic [7:0]  out_a,
    output logic [7:0]  out_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] instr_r;
    logic [7:0]  out_a_r;
    logic [7:0]  out_b_r;
    logic        out_valid_r;

    logic        wr_cycle_s;
    logic        imm_form_s;
    logic [2:0]  rs_s;
    logic [2:0]  rt_s;
    logic [7:0]  a_next_s;
    logic [7:0]  b_next_s;
    logic [7:0]  a_hold_s;
    logic [7:0]  b_hold_s;

    function automatic logic [7:0] sext6(input logic [5:0] imm);
        return {{2{imm[5]}}, imm};
    endfunction

    // r0 always reads zero; a matching write in this cycle overrides the base value.
    function automatic logic [7:0] pick_operand(
        input logic [2:0] src,
        input logic [7:0] base,
        input logic       wr,
        input logic [2:0] wr_idx,
        input logic [7:0] wr_val
    );
        logic [7:0] res;
        if (src == 3'd0) begin
            res = 8'h00;
        end else if (wr && (wr_idx == src)) begin
            res = wr_val;
        end else begin
            res = base;
        end
        return res;
    endfunction

    // Writeback pass-through and field decode of the latched instruction.
    always_comb begin
        rf_rw      = wb_valid;
        rf_rd      = wb_rd;
        rf_rd_data = wb_data;
        wr_cycle_s = wb_valid && (wb_rd != 3'd0);
        imm_form_s = instr_r[15];
        rs_s       = instr_r[8:6];
        rt_s       = instr_r[5:3];
        rf_rs      = rs_s;
        rf_rt      = rt_s;
        out_op     = instr_r[15:12];
        out_rd     = instr_r[11:9];
        out_valid  = out_valid_r;
        out_a      = out_a_r;
        out_b      = out_b_r;
    end

    // Operand selection for capture in WAIT and for refreshing held operands in ISSUE.
    always_comb begin
        a_next_s = pick_operand(rs_s, rf_rs_data, wr_cycle_s, wb_rd, wb_data);
        a_hold_s = pick_operand(rs_s, out_a_r, wr_cycle_s, wb_rd, wb_data);
        if (imm_form_s) begin
            b_next_s = sext6(instr_r[5:0]);
            b_hold_s = out_b_r;
        end else begin
            b_next_s = pick_operand(rt_s, rf_rt_data, wr_cycle_s, wb_rd, wb_data);
            b_hold_s = pick_operand(rt_s, out_b_r, wr_cycle_s, wb_rd, wb_data);
        end
    end

    // Accept when idle, or in ISSUE as soon as execute takes the current bundle.
    always_comb begin
        if (state_r == IDLE) begin
            in_ready = 1'b1;
        end else if (state_r == ISSUE) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Main FSM; the register file cannot read during a write cycle, so READ stalls then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            instr_r     <= 16'h0000;
            out_a_r     <= 8'h00;
            out_b_r     <= 8'h00;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        instr_r <= in_instr;
                        state_r <= READ;
                    end
                end
                READ: begin
                    if (!wr_cycle_s) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    out_a_r     <= a_next_s;
                    out_b_r     <= b_next_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ISSUE;
                end
                ISSUE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            instr_r <= in_instr;
                            state_r <= READ;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        out_a_r <= a_hold_s;
                        out_b_r <= b_hold_s;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 8-bit x 7 register file
// (registered reads, no read in a write cycle, r0 reads zero).
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data;
    logic [2:0]  rf_rs;
    logic [2:0]  rf_rt;
    logic [2:0]  rf_rd;
    logic        rf_rw;
    logic [7:0]  rf_rd_data;
    logic [7:0]  rf_rs_data;
    logic [7:0]  rf_rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_rd;
    logic [7:0]  out_a;
    logic [7:0]  out_b;

    int checks;
    int errors;

    logic [7:0] regs [0:7];

    operand_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rf_rs      (rf_rs),
        .rf_rt      (rf_rt),
        .rf_rd      (rf_rd),
        .rf_rw      (rf_rw),
        .rf_rd_data (rf_rd_data),
        .rf_rs_data (rf_rs_data),
        .rf_rt_data (rf_rt_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_rd     (out_rd),
        .out_a      (out_a),
        .out_b      (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: a write cycle writes and suppresses the read.
    always @(posedge clk) begin
        if (rf_rw && (rf_rd != 3'd0)) begin
            regs[rf_rd] <= rf_rd_data;
        end else begin
            rf_rs_data <= (rf_rs == 3'd0) ? 8'h00 : regs[rf_rs];
            rf_rt_data <= (rf_rt == 3'd0) ? 8'h00 : regs[rf_rt];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rf(input logic [2:0] idx, input logic [7:0] val);
        wb_valid = 1'b1;
        wb_rd    = idx;
        wb_data  = val;
        tick();
        wb_valid = 1'b0;
        wb_rd    = 3'd0;
        wb_data  = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #22;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_op !== 4'h0) begin errors++; $display("FAIL reset_out_op: got %h want 0", out_op); end
        checks++; if (out_rd !== 3'd0) begin errors++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
        checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL reset_out_a: got %h want 00", out_a); end
        checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL reset_out_b: got %h want 00", out_b); end
        checks++; if (rf_rs !== 3'd0 || rf_rt !== 3'd0) begin errors++; $display("FAIL reset_rf_idx: got rs=%0d rt=%0d want 0 0", rf_rs, rf_rt); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic preload();
        set_rf(3'd1, 8'h05);
        set_rf(3'd2, 8'h11);
        set_rf(3'd3, 8'h22);
        set_rf(3'd5, 8'h10);
        set_rf(3'd6, 8'h33);
        set_rf(3'd7, 8'h44);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL preload_idle: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_instr = 16'h1698; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0; #1;
        checks++; if (rf_rs !== 3'd2 || rf_rt !== 3'd3) begin errors++; $display("FAIL basic_rf_idx: got rs=%0d rt=%0d want 2 3", rf_rs, rf_rt); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_c1: got valid=%b ready=%b want 0 0", out_valid, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_c2_valid: got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_c3_valid: got %b want 1", out_valid); end
        checks++; if (out_a !== 8'h11 || out_b !== 8'h22) begin errors++; $display("FAIL basic_ab: got a=%h b=%h want 11 22", out_a, out_b); end
        checks++; if (out_op !== 4'h1 || out_rd !== 3'd3) begin errors++; $display("FAIL basic_op_rd: got op=%h rd=%0d want 1 3", out_op, out_rd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_issue_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_immediate();
        in_valid = 1'b1; in_instr = 16'h827E;
        tick(); in_valid = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL imm_valid: got %b want 1", out_valid); end
        checks++; if (out_a !== 8'h05 || out_b !== 8'hFE) begin errors++; $display("FAIL imm_ab: got a=%h b=%h want 05 fe", out_a, out_b); end
        checks++; if (out_op !== 4'h8 || out_rd !== 3'd1) begin errors++; $display("FAIL imm_op_rd: got op=%h rd=%0d want 8 1", out_op, out_rd); end
        tick();
    endtask

    task automatic test_write_stall();
        in_valid = 1'b1; in_instr = 16'h2310;
        tick(); in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 3'd4; wb_data = 8'h7F;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (rf_rw !== 1'b1 || rf_rd !== 3'd4 || rf_rd_data !== 8'h7F) begin errors++; $display("FAIL stall_pass_c%0d: got rw=%b rd=%0d d=%h want 1 4 7f", c, rf_rw, rf_rd, rf_rd_data); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_c%0d: got %b want 0", c, out_valid); end
            tick();
        end
        wb_valid = 1'b0; wb_rd = 3'd0; wb_data = 8'h00;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_c5_valid: got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_c6_valid: got %b want 1", out_valid); end
        checks++; if (out_a !== 8'h7F || out_b !== 8'h11) begin errors++; $display("FAIL stall_ab: got a=%h b=%h want 7f 11", out_a, out_b); end
        tick();
    endtask

    task automatic test_forward_wait();
        in_valid = 1'b1; in_instr = 16'h3558;
        tick(); in_valid = 1'b0;
        tick();
        wb_valid = 1'b1; wb_rd = 3'd5; wb_data = 8'h99;
        tick();
        wb_valid = 1'b0; wb_rd = 3'd0; wb_data = 8'h00; #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b want 1", out_valid); end
        checks++; if (out_a !== 8'h99 || out_b !== 8'h22) begin errors++; $display("FAIL fwd_ab: got a=%h b=%h want 99 22", out_a, out_b); end
        tick();
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_instr = 16'h4AB0;
        tick(); in_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h1698; #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_c3: got valid=%b ready=%b want 1 0", out_valid, in_ready); end
        checks++; if (out_a !== 8'h11 || out_b !== 8'h33) begin errors++; $display("FAIL bp_c3_ab: got a=%h b=%h want 11 33", out_a, out_b); end
        tick();
        wb_valid = 1'b1; wb_rd = 3'd6; wb_data = 8'hAB; #1;
        checks++; if (out_b !== 8'h33 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_c4: got b=%h ready=%b want 33 0", out_b, in_ready); end
        tick();
        wb_valid = 1'b0; wb_rd = 3'd0; wb_data = 8'h00; #1;
        checks++; if (out_b !== 8'hAB) begin errors++; $display("FAIL bp_hold_fwd_b: got %h want ab", out_b); end
        checks++; if (out_a !== 8'h11 || out_op !== 4'h4 || out_rd !== 3'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable: got a=%h op=%h rd=%0d v=%b want 11 4 5 1", out_a, out_op, out_rd, out_valid); end
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_c6: got ready=%b valid=%b want 0 1", in_ready, out_valid); end
        tick();
        out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_c8_valid: got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_c9_valid: got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
        checks++; if (out_a !== 8'h11 || out_b !== 8'h22 || out_op !== 4'h1) begin errors++; $display("FAIL bp_next_bundle: got a=%h b=%h op=%h want 11 22 1", out_a, out_b, out_op); end
        tick();
    endtask

    task automatic test_r0_and_reset();
        in_valid = 1'b1; in_instr = 16'h5000;
        tick(); in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 3'd0; wb_data = 8'h55; #1;
        checks++; if (rf_rw !== 1'b1 || rf_rd_data !== 8'h55) begin errors++; $display("FAIL r0_pass: got rw=%b d=%h want 1 55", rf_rw, rf_rd_data); end
        tick(); tick();
        wb_valid = 1'b0; wb_data = 8'h00; #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL r0_no_stall: got %b want 1", out_valid); end
        checks++; if (out_a !== 8'h00 || out_b !== 8'h00) begin errors++; $display("FAIL r0_ab: got a=%h b=%h want 00 00", out_a, out_b); end
        tick();
        // reset asserted while the next instruction is in WAIT
        in_valid = 1'b1; in_instr = 16'h1698;
        tick(); in_valid = 1'b0;
        tick();
        reset = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || rf_rs !== 3'd0 || rf_rt !== 3'd0) begin errors++; $display("FAIL rst_wait: got v=%b rs=%0d rt=%0d want 0 0 0", out_valid, rf_rs, rf_rt); end
        tick();
        reset = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale_c%0d: got %b want 0", c, out_valid); end
        end
        // reset asserted while a bundle is being presented
        in_valid = 1'b1; in_instr = 16'h1698; out_ready = 1'b0;
        tick(); in_valid = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_a !== 8'h11) begin errors++; $display("FAIL rst_pre_issue: got v=%b a=%h want 1 11", out_valid, out_a); end
        reset = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || out_a !== 8'h00 || out_b !== 8'h00) begin errors++; $display("FAIL rst_issue: got v=%b a=%h b=%h want 0 00 00", out_valid, out_a, out_b); end
        tick();
        reset = 1'b1; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_after: got v=%b ready=%b want 0 1", out_valid, in_ready); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        wb_valid  = 1'b0;
        wb_rd     = 3'd0;
        wb_data   = 8'h00;
        out_ready = 1'b1;
        test_reset();
        preload();
        test_basic();
        test_immediate();
        test_write_stall();
        test_forward_wait();
        test_backpressure();
        test_r0_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
